// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared opcodes, FSM state type and default width for alu_sequencer
package alu_seq_pkg;

  localparam int ALU_W_DEFAULT = 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXEC   = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - sequences one command through a clocked ALU; optional accumulator under ALU_SEQ_ACC_EN
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int W     = ALU_W_DEFAULT,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [W-1:0]     cmd_a,
  input  logic [W-1:0]     cmd_b,
`ifdef ALU_SEQ_ACC_EN
  input  logic             cmd_acc,
`endif
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [2:0]       alu_op,
  input  logic [W-1:0]     alu_result,
  input  logic             alu_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [W-1:0]     rsp_result,
  output logic             rsp_carry,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  state_t state;
  state_t state_nxt;

  logic         accept;
  logic         rsp_hs;
  logic [W-1:0] op_a_sel;

  assign accept = cmd_valid && (state == ST_IDLE);
  assign rsp_hs = rsp_ready && (state == ST_RESP);

`ifdef ALU_SEQ_ACC_EN
  logic [W-1:0] acc;

  // Accumulator tracks the last result that was actually handed off
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         acc <= '0;
    else if (rsp_hs) acc <= rsp_result;
  end

  assign op_a_sel = cmd_acc ? acc : cmd_a;
`else
  assign op_a_sel = cmd_a;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state: fixed two-cycle walk to RESP, then wait for the consumer
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (cmd_valid) state_nxt = ST_EXEC;
      ST_EXEC:   state_nxt = ST_SAMPLE;
      ST_SAMPLE: state_nxt = ST_RESP;
      ST_RESP:   if (rsp_ready) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Handshake/status outputs decoded from state only
  always_comb begin
    cmd_ready = (state == ST_IDLE);
    busy      = (state != ST_IDLE);
  end

  // ALU operand drive, loaded on accept and held otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= OP_ADD;
    end else if (accept) begin
      alu_a  <= op_a_sel;
      alu_b  <= cmd_b;
      alu_op <= cmd_op;
    end
  end

  // Response capture; carry is masked because the ALU leaves it stale on non-arithmetic ops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      op_count   <= '0;
    end else if (state == ST_SAMPLE) begin
      rsp_valid  <= 1'b1;
      rsp_result <= alu_result;
      rsp_carry  <= ((alu_op == OP_ADD) || (alu_op == OP_SUB)) ? alu_carry : 1'b0;
    end else if (rsp_hs) begin
      rsp_valid  <= 1'b0;
      op_count   <= op_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - scoreboard bench for alu_sequencer with a clocked ALU beside it
module tb_alu_sequencer;

  localparam int W     = 4;
  localparam int CNT_W = 8;
`ifdef ALU_SEQ_ACC_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [2:0]       cmd_op = 3'd0;
  logic [W-1:0]     cmd_a = '0;
  logic [W-1:0]     cmd_b = '0;
  logic             cmd_acc = 1'b0;
  logic [W-1:0]     alu_a;
  logic [W-1:0]     alu_b;
  logic [2:0]       alu_op;
  logic [W-1:0]     alu_result = '0;
  logic             alu_carry = 1'b0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [W-1:0]     rsp_result;
  logic             rsp_carry;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  int checks = 0;
  int failures = 0;

  typedef struct { int result; int carry; } exp_t;
  exp_t exp_q[$];

  int model_cnt = 0;
  int model_acc = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
`ifdef ALU_SEQ_ACC_EN
    .cmd_acc(cmd_acc),
`endif
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry),
    .busy(busy), .op_count(op_count)
  );

  // Clocked ALU: carry only updates on add/sub, stale otherwise
  always @(posedge clk) begin
    case (alu_op)
      3'd0: {alu_carry, alu_result} <= {1'b0, alu_a} + {1'b0, alu_b};
      3'd1: {alu_carry, alu_result} <= {1'b0, alu_a} - {1'b0, alu_b};
      3'd2: alu_result <= alu_a & alu_b;
      3'd3: alu_result <= alu_a | alu_b;
      3'd4: alu_result <= alu_a ^ alu_b;
      3'd5: alu_result <= ~alu_a;
      3'd6: alu_result <= alu_a << 1;
      default: alu_result <= alu_a >> 1;
    endcase
  end

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Reference: what the response should be, from plain integer arithmetic
  function automatic exp_t ref_op(input int op, input int a, input int b);
    exp_t e;
    int m = 1 << W;
    e.carry = 0;
    case (op)
      0: begin e.result = (a + b) % m; e.carry = (a + b >= m) ? 1 : 0; end
      1: begin e.result = (a - b + m) % m; e.carry = (a < b) ? 1 : 0; end
      2: e.result = a & b;
      3: e.result = a | b;
      4: e.result = a ^ b;
      5: e.result = (m - 1) - a;
      6: e.result = (a * 2) % m;
      default: e.result = a / 2;
    endcase
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: compare whenever a response handshake is about to occur
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_result", int'(rsp_result), e.result);
        check("rsp_carry", int'(rsp_carry), e.carry);
      end
    end
  end

  task automatic do_op(input int op, input int a, input int b, input bit acc,
                       input int hold, input bit pulse, output int res);
    exp_t e;
    int n;
    int snap_r;
    int snap_c;
    n = 0;
    while (!cmd_ready && n < 20) begin tick(); n++; end
    if (!cmd_ready) check("cmd_ready_timeout", 0, 1);
    e = ref_op(op, (ACC_EN && acc) ? model_acc : a, b);
    exp_q.push_back(e);
    res = e.result;
    cmd_valid = 1'b1;
    cmd_op = 3'(op);
    cmd_a = W'(a);
    cmd_b = W'(b);
    cmd_acc = acc;
    tick();
    cmd_valid = 1'b0;
    check("busy_after_accept", int'(busy), 1);
    check("cmd_ready_exec", int'(cmd_ready), 0);
    check("rsp_valid_e1", int'(rsp_valid), 0);
    tick();
    check("rsp_valid_e2", int'(rsp_valid), 0);
    tick();
    check("rsp_valid_latency", int'(rsp_valid), 1);
    snap_r = int'(rsp_result);
    snap_c = int'(rsp_carry);
    for (int i = 0; i < hold; i++) begin
      if (pulse && i == 1) cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      check("hold_valid", int'(rsp_valid), 1);
      check("hold_result", int'(rsp_result), snap_r);
      check("hold_carry", int'(rsp_carry), snap_c);
      check("hold_cmd_ready", int'(cmd_ready), 0);
      check("hold_op_count", int'(op_count), model_cnt);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    model_cnt = (model_cnt + 1) % (1 << CNT_W);
    model_acc = e.result;
    check("rsp_valid_cleared", int'(rsp_valid), 0);
    check("cmd_ready_after_hs", int'(cmd_ready), 1);
    check("op_count", int'(op_count), model_cnt);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_cnt = 0;
    model_acc = 0;
    tick();
    rst = 1'b0;
    check("cmd_ready_post_reset", int'(cmd_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    tick();
    tick();
    check("rst_rsp_valid", int'(rsp_valid), 0);
    check("rst_op_count", int'(op_count), 0);
    check("rst_alu_a", int'(alu_a), 0);
    rst = 1'b0;
    check("first_cmd_ready", int'(cmd_ready), 1);
    check("first_busy", int'(busy), 0);

    do_op(0, 9, 8, 1'b0, 0, 1'b0, r);
    check("add_ovf_result", r, 1);
    do_op(1, 3, 5, 1'b0, 0, 1'b0, r);
    check("sub_borrow_result", r, 14);
    do_op(0, 15, 15, 1'b0, 0, 1'b0, r);
    do_op(2, 12, 10, 1'b0, 0, 1'b0, r);
    check("and_stale_result", r, 8);

    do_op(4, 6, 3, 1'b0, 4, 1'b1, r);
    check("q_empty_after_bp", exp_q.size(), 0);

    // reset while in SAMPLE: in-flight op dropped
    while (!cmd_ready) tick();
    cmd_valid = 1'b1; cmd_op = 3'd0; cmd_a = 4'd7; cmd_b = 4'd7; cmd_acc = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("rst_async_valid", int'(rsp_valid), 0);
    check("rst_async_busy", int'(busy), 0);
    check("rst_async_alu_a", int'(alu_a), 0);
    check("rst_async_alu_b", int'(alu_b), 0);
    check("rst_async_alu_op", int'(alu_op), 0);
    check("rst_async_result", int'(rsp_result), 0);
    check("rst_async_carry", int'(rsp_carry), 0);
    check("rst_async_count", int'(op_count), 0);
    do_reset();
    tick();
    tick();
    check("no_rsp_after_drop", int'(rsp_valid), 0);

`ifdef ALU_SEQ_ACC_EN
    do_op(0, 5, 0, 1'b0, 0, 1'b0, r);
    do_op(0, 1, 3, 1'b1, 1, 1'b0, r);
    check("acc_add", r, 8);
`endif

    for (int i = 0; i < 40; i++) begin
      do_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 15)), ACC_EN ? 1'($urandom_range(0, 1)) : 1'b0,
            int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), r);
    end

    do_reset();
    for (int i = 0; i < 256; i++) begin
      do_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 15)), 1'b0, 0, 1'b0, r);
    end
    check("op_count_wrap", int'(op_count), 0);

    tick();
    check("q_empty_end", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
